regfile_wb_arbiter: RTL and testbench

- Shares the register file's two write ports (inst1/inst2: waddr, 4-bit byte enable, wdata) among NUM_REQ writeback requesters (e.g. ALU0, ALU1, MDU, LSU).
- Grants up to two writes per cycle using round-robin with starvation override, and forbids same-address dual writes.
- Registers the selected writes onto the regfile write ports.
- Sits between the execute/commit stage and the register file.

---
 rtl/regfile_wb_arbiter_pkg.sv | 22 ++
 rtl/regfile_wb_arbiter_if.sv | 23 ++
 rtl/regfile_wb_arbiter_rr_pick.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback types: register address, data word and the per-requester write request.
package regfile_wb_arbiter_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] uint32_t;

    typedef struct packed {
        reg_addr_t  waddr;
        logic [3:0] we;
        uint32_t    wdata;
    } wb_req_t;

    localparam int WB_NUM_REQ      = 4;
    localparam int WB_STARVE_LIMIT = 7;
    localparam int WB_CW           = 3;

    // A write to x0 or with no byte enables is acknowledged without using a port.
    function automatic logic wb_is_null(input wb_req_t r);
        return (r.waddr == '0) || (r.we == '0);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: NUM_REQ packed requesters (requester 0 in the LSBs) with valid/ready.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = regfile_wb_arbiter_pkg::WB_NUM_REQ
) ();
    import regfile_wb_arbiter_pkg::*;

    logic      [NUM_REQ-1:0]      req_valid;
    logic      [NUM_REQ-1:0]      req_ready;
    reg_addr_t [NUM_REQ-1:0]      req_waddr;
    logic      [NUM_REQ-1:0][3:0] req_we;
    uint32_t   [NUM_REQ-1:0]      req_wdata;

    modport master (
        output req_valid, req_waddr, req_we, req_wdata,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_waddr, req_we, req_wdata,
        output req_ready
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// First-one finder: starved candidates win lowest index first, otherwise rotate from ptr_i.
module regfile_wb_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  cand_i,
    input  logic [N-1:0]  starved_i,
    input  logic [N-1:0]  excl_i,
    input  logic [PW-1:0] ptr_i,
    output logic          gnt_vld_o,
    output logic [PW-1:0] gnt_idx_o
);
    logic [N-1:0]  elig;
    logic [N-1:0]  elig_starved;
    logic [PW-1:0] slot;

    // NOTE: every output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        elig         = cand_i & ~excl_i;
        elig_starved = elig & starved_i;
        gnt_vld_o    = 1'b0;
        gnt_idx_o    = '0;
        slot         = '0;
        // Scan downwards so the last hit written is the highest-priority one.
        for (int i = N - 1; i >= 0; i--) begin
            if (elig_starved[i]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = PW'(i);
            end
        end
        if (!gnt_vld_o) begin
            for (int k = N - 1; k >= 0; k--) begin
                slot = PW'((int'(ptr_i) + k) % N);
                if (elig[slot]) begin
                    gnt_vld_o = 1'b1;
                    gnt_idx_o = slot;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the two registered regfile write ports,
// round-robin with starvation override and no same-register dual writes.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = WB_NUM_REQ,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT,
    parameter int CW           = WB_CW
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_arbiter_if.slave wb,
    output logic [3:0]          inst1_we,
    output reg_addr_t           inst1_waddr,
    output uint32_t             inst1_wdata,
    output logic [3:0]          inst2_we,
    output reg_addr_t           inst2_waddr,
    output uint32_t             inst2_wdata
);
    localparam int PW = $clog2(NUM_REQ);

    wb_req_t [NUM_REQ-1:0] req;
    logic    [NUM_REQ-1:0] null_ack, cand, starved, same_addr, excl2, g1_oh, g2_oh;
    logic                  g1_vld, g2_vld;
    logic    [PW-1:0]      g1_idx, g2_idx, last_idx;
    logic    [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic    [CW-1:0]      starve_cnt_q [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i].waddr = wb.req_waddr[i];
            req[i].we    = wb.req_we[i];
            req[i].wdata = wb.req_wdata[i];
            null_ack[i]  = wb.req_valid[i] && wb_is_null(req[i]);
            cand[i]      = wb.req_valid[i] && !wb_is_null(req[i]);
            starved[i]   = (starve_cnt_q[i] == CW'(STARVE_LIMIT));
        end
    end

    regfile_wb_arbiter_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_g1 (
        .cand_i    (cand),
        .starved_i (starved),
        .excl_i    ({NUM_REQ{1'b0}}),
        .ptr_i     (rr_ptr_q),
        .gnt_vld_o (g1_vld),
        .gnt_idx_o (g1_idx)
    );

    // Port 2 skips port 1's winner and anyone targeting the same register.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            same_addr[i] = (req[i].waddr == req[g1_idx].waddr);
            g1_oh[i]     = g1_vld && (g1_idx == PW'(i));
        end
        excl2 = same_addr | g1_oh;
    end

    regfile_wb_arbiter_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_g2 (
        .cand_i    (cand),
        .starved_i (starved),
        .excl_i    (excl2),
        .ptr_i     (rr_ptr_q),
        .gnt_vld_o (g2_vld),
        .gnt_idx_o (g2_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            g2_oh[i] = g2_vld && (g2_idx == PW'(i));
        end
        wb.req_ready = reset ? '0 : (null_ack | g1_oh | g2_oh);
        last_idx     = g2_vld ? g2_idx : g1_idx;
        rr_ptr_d     = rr_ptr_q;
        if (g1_vld) begin
            rr_ptr_d = (last_idx == PW'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
        end
    end

    // NOTE: the counter array is real control state, so every entry is cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            inst1_we    <= '0;
            inst1_waddr <= '0;
            inst1_wdata <= '0;
            inst2_we    <= '0;
            inst2_waddr <= '0;
            inst2_wdata <= '0;
            for (int i = 0; i < NUM_REQ; i++) starve_cnt_q[i] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!wb.req_valid[i] || wb.req_ready[i]) starve_cnt_q[i] <= '0;
                else if (!starved[i])                    starve_cnt_q[i] <= starve_cnt_q[i] + 1'b1;
            end
            inst1_we <= g1_vld ? req[g1_idx].we : 4'b0000;
            inst2_we <= g2_vld ? req[g2_idx].we : 4'b0000;
            if (g1_vld) begin
                inst1_waddr <= req[g1_idx].waddr;
                inst1_wdata <= req[g1_idx].wdata;
            end
            if (g2_vld) begin
                inst2_waddr <= req[g2_idx].waddr;
                inst2_wdata <= req[g2_idx].wdata;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: a priority-list reference model predicts ready and port writes each cycle.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int N     = 4;
    localparam int LIMIT = 7;

    typedef struct {
        logic [3:0] we1;
        reg_addr_t  a1;
        uint32_t    d1;
        logic [3:0] we2;
        reg_addr_t  a2;
        uint32_t    d2;
        bit         full;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] inst1_we, inst2_we;
    reg_addr_t  inst1_waddr, inst2_waddr;
    uint32_t    inst1_wdata, inst2_wdata;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(N)) wb ();

    regfile_wb_arbiter #(.NUM_REQ(N), .STARVE_LIMIT(LIMIT), .CW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb          (wb),
        .inst1_we    (inst1_we),
        .inst1_waddr (inst1_waddr),
        .inst1_wdata (inst1_wdata),
        .inst2_we    (inst2_we),
        .inst2_waddr (inst2_waddr),
        .inst2_wdata (inst2_wdata)
    );

    int         checks   = 0;
    int         failures = 0;
    exp_t       sb_q[$];
    logic [N-1:0] d_valid = '0;
    wb_req_t    d_req [N];
    int         m_rr = 0;
    int         m_cnt [N];
    uint32_t    exp_rf [32];
    uint32_t    dut_rf [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic uint32_t merge(input uint32_t old, input logic [3:0] we, input uint32_t d);
        uint32_t r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic new_req(input int i, input reg_addr_t a, input logic [3:0] we, input uint32_t d);
        d_valid[i]     = 1'b1;
        d_req[i].waddr = a;
        d_req[i].we    = we;
        d_req[i].wdata = d;
    endtask

    // One arbitration cycle: drive, predict, check ready mid-cycle, then advance the model.
    task automatic step(input bit rst, input bit want_en = 1'b0, input logic [N-1:0] want = '0);
        logic [N-1:0] exp_ready = '0;
        int   g1 = -1;
        int   g2 = -1;
        int   prio[$];
        bit   listed [N];
        exp_t e;
        reset = rst;
        for (int i = 0; i < N; i++) begin
            wb.req_valid[i] = d_valid[i];
            wb.req_waddr[i] = d_req[i].waddr;
            wb.req_we[i]    = d_req[i].we;
            wb.req_wdata[i] = d_req[i].wdata;
            listed[i]       = 1'b0;
        end
        e.we1 = '0; e.a1 = '0; e.d1 = '0; e.we2 = '0; e.a2 = '0; e.d2 = '0; e.full = rst;
        if (!rst) begin
            for (int i = 0; i < N; i++)
                if (d_valid[i] && m_cnt[i] == LIMIT) begin prio.push_back(i); listed[i] = 1'b1; end
            for (int k = 0; k < N; k++)
                if (!listed[(m_rr + k) % N]) prio.push_back((m_rr + k) % N);
            foreach (prio[p]) begin
                int i;
                i = prio[p];
                if (!d_valid[i]) continue;
                if (d_req[i].waddr == 0 || d_req[i].we == 0) exp_ready[i] = 1'b1;
                else if (g1 < 0) begin g1 = i; exp_ready[i] = 1'b1; end
                else if (g2 < 0 && d_req[i].waddr != d_req[g1].waddr) begin g2 = i; exp_ready[i] = 1'b1; end
            end
            if (g1 >= 0) begin e.we1 = d_req[g1].we; e.a1 = d_req[g1].waddr; e.d1 = d_req[g1].wdata; end
            if (g2 >= 0) begin e.we2 = d_req[g2].we; e.a2 = d_req[g2].waddr; e.d2 = d_req[g2].wdata; end
        end
        @(negedge clk);
        check("req_ready", wb.req_ready, exp_ready);
        if (want_en) check("req_ready_directed", wb.req_ready, want);
        @(posedge clk);
        sb_q.push_back(e);
        if (rst) begin
            m_rr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            d_valid = '0;
        end else begin
            for (int i = 0; i < N; i++)
                m_cnt[i] = (!d_valid[i] || exp_ready[i]) ? 0 : ((m_cnt[i] < LIMIT) ? m_cnt[i] + 1 : LIMIT);
            if (g2 >= 0) m_rr = (g2 + 1) % N;
            else if (g1 >= 0) m_rr = (g1 + 1) % N;
            if (g1 >= 0) exp_rf[e.a1] = merge(exp_rf[e.a1], e.we1, e.d1);
            if (g2 >= 0) exp_rf[e.a2] = merge(exp_rf[e.a2], e.we2, e.d2);
            d_valid = d_valid & ~exp_ready;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0);
    endtask

    task automatic compare_rf();
        for (int r = 0; r < 32; r++) check($sformatf("regfile[%0d]", r), dut_rf[r], exp_rf[r]);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("inst1_we", inst1_we, e.we1);
                check("inst2_we", inst2_we, e.we2);
                if (e.full || e.we1 != 0) begin
                    check("inst1_waddr", inst1_waddr, e.a1);
                    check("inst1_wdata", inst1_wdata, e.d1);
                end
                if (e.full || e.we2 != 0) begin
                    check("inst2_waddr", inst2_waddr, e.a2);
                    check("inst2_wdata", inst2_wdata, e.d2);
                end
                if (inst1_we != 0) dut_rf[inst1_waddr] = merge(dut_rf[inst1_waddr], inst1_we, inst1_wdata);
                if (inst2_we != 0) dut_rf[inst2_waddr] = merge(dut_rf[inst2_waddr], inst2_we, inst2_wdata);
            end
        end
    end

    initial begin : stimulus
        for (int r = 0; r < 32; r++) begin exp_rf[r] = '0; dut_rf[r] = '0; end
        for (int i = 0; i < N; i++) begin m_cnt[i] = 0; d_req[i] = '0; end

        step(1'b1, 1'b1, 4'b0000);
        step(1'b1, 1'b1, 4'b0000);

        // Four requesters to distinct registers: two per cycle.
        for (int i = 0; i < N; i++) new_req(i, reg_addr_t'(i + 1), 4'hF, 32'h1000_0000 * (i + 1) + 32'h55);
        step(1'b0, 1'b1, 4'b0011);
        step(1'b0, 1'b1, 4'b1100);
        idle(2);
        compare_rf();

        // Same-address pair: serialised, byte lanes combine.
        new_req(0, 5'd5, 4'b0011, 32'hAAAA_1111);
        new_req(1, 5'd5, 4'b1100, 32'h2222_BBBB);
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0010);
        idle(2);
        check("reg5_combined", dut_rf[5], 32'h2222_1111);

        // Null requests acknowledged without a write.
        new_req(2, 5'd0, 4'hF, 32'hDEAD_BEEF);
        new_req(3, 5'd6, 4'h0, 32'hCAFE_F00D);
        step(1'b0, 1'b1, 4'b1100);
        idle(1);

        // Rotate pointer to 1, then r3 shares r1's register and starves until the override.
        new_req(0, 5'd9, 4'hF, 32'h0000_0009);
        step(1'b0, 1'b1, 4'b0001);
        new_req(3, 5'd11, 4'hF, 32'h3333_3333);
        for (int c = 0; c < LIMIT; c++) begin
            new_req(0, 5'd10, 4'hF, 32'h0A00_0000 + c);
            new_req(1, 5'd11, 4'hF, 32'h0B00_0000 + c);
            step(1'b0, 1'b1, 4'b0011);
        end
        new_req(0, 5'd10, 4'hF, 32'h0A00_00FF);
        new_req(1, 5'd11, 4'hF, 32'h0B00_00FF);
        step(1'b0, 1'b1, 4'b1001);
        idle(3);
        compare_rf();

        // Reset in the cycle after a dual grant clears pointer and counters.
        new_req(0, 5'd12, 4'hF, 32'h1212_1212);
        new_req(1, 5'd13, 4'hF, 32'h1313_1313);
        step(1'b0, 1'b1, 4'b0011);
        step(1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < N; i++) new_req(i, reg_addr_t'(i + 20), 4'hF, 32'h2000_0000 + i);
        step(1'b0, 1'b1, 4'b0011);
        step(1'b0, 1'b1, 4'b1100);
        idle(2);
        compare_rf();

        // Single requester streaming back-to-back.
        for (int c = 0; c < 8; c++) begin
            new_req(1, reg_addr_t'($urandom_range(1, 31)), 4'($urandom_range(1, 15)), $urandom());
            step(1'b0, 1'b1, 4'b0010);
        end
        idle(2);
        compare_rf();

        // Random traffic with frequent address collisions, null requests and occasional reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!d_valid[i] && $urandom_range(0, 1) == 1)
                    new_req(i, reg_addr_t'($urandom_range(0, 7)),
                            ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom());
            step($urandom_range(0, 99) == 0);
        end
        for (int c = 0; c < 20 && d_valid != '0; c++) step(1'b0);
        check("requests_drained", d_valid, '0);
        idle(2);
        compare_rf();
        @(negedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
